// File: rtl/cache_pipe_model_if.sv
// Request/response handshake bundle for the cache array model.
// Master drives requests and pops; slave is the model.
interface cache_pipe_model_if #(
    parameter int REQ_W = 70,
    parameter int RSP_W = 52
);
    logic             put_valid;
    logic [REQ_W-1:0] put_request;
    logic             put_ready;
    logic             get_valid;
    logic             get_ready;
    logic [RSP_W-1:0] get_response;

    modport master (
        output put_valid, put_request, get_valid,
        input  put_ready, get_ready, get_response
    );

    modport slave (
        input  put_valid, put_request, get_valid,
        output put_ready, get_ready, get_response
    );
endinterface

// File: rtl/cache_pipe_model.sv
// Direct-mapped cache array model: in-order row read/merge/write with
// a fixed-latency response pipe feeding a credit-limited show-ahead FIFO.
module cache_pipe_model #(
    parameter int          TAG_WIDTH   = 18,
    parameter int          INDEX_WIDTH = 12,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MSI_WIDTH   = 2,
    parameter int          LATENCY     = 1,
    parameter int          QDEPTH      = 4,
    parameter logic [31:0] EXIT_ADDR0  = 32'h40001000,
    parameter logic [31:0] EXIT_ADDR1  = 32'h80001000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    cache_pipe_model_if.slave     bus,
    output logic                  finish,
    output logic [DATA_WIDTH-1:0] exit_code
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int RSP_W = TAG_WIDTH + DATA_WIDTH + MSI_WIDTH;
    localparam int ROWS  = 1 << INDEX_WIDTH;
    localparam int AW    = $clog2(QDEPTH);
    localparam int BS    = $clog2(BE_W);
    localparam int FA    = TAG_WIDTH + INDEX_WIDTH + BS;
    localparam int PS    = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [AW:0] QFULL = (AW + 1)'(QDEPTH);

    logic [BE_W-1:0]        req_be;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [DATA_WIDTH-1:0]  req_data;
    logic                   req_mv;
    logic [MSI_WIDTH-1:0]   req_msi;
    logic                   req_ign;

    assign {req_be, req_tag, req_idx, req_data,
            req_mv, req_msi, req_ign} = bus.put_request;

    logic [TAG_WIDTH-1:0]  mem_tag  [ROWS];
    logic [DATA_WIDTH-1:0] mem_data [ROWS];
    logic [MSI_WIDTH-1:0]  mem_msi  [ROWS];

    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] merged;
    logic                  acc;
    logic                  in_v;
    logic [RSP_W-1:0]      in_d;

    always_comb begin
        mask = '0;
        for (int b = 0; b < BE_W; b++)
            mask[8*b +: 8] = {8{req_be[b]}};
    end

    assign acc    = bus.put_valid && bus.put_ready;
    assign in_v   = acc && !req_ign;
    assign in_d   = {mem_tag[req_idx], mem_data[req_idx], mem_msi[req_idx]};
    assign merged = (mem_data[req_idx] & ~mask) | (req_data & mask);

    // Row contents survive reset; only accepted requests touch them.
    always_ff @(posedge CLK) begin
        if (acc) begin
            if (req_be != '0) begin
                mem_tag[req_idx]  <= req_tag;
                mem_data[req_idx] <= merged;
            end
            if (req_mv)
                mem_msi[req_idx] <= req_msi;
        end
    end

    logic [PS-1:0]    pv_q;
    logic [RSP_W-1:0] pd_q [PS];
    logic             push;
    logic [RSP_W-1:0] push_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= in_v;
            for (int i = 1; i < PS; i++)
                pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        pd_q[0] <= in_d;
        for (int i = 1; i < PS; i++)
            pd_q[i] <= pd_q[i-1];
    end

    // LATENCY==1 writes the FIFO straight from the accepting edge.
    assign push   = (LATENCY == 1) ? in_v : pv_q[PS-1];
    assign push_d = (LATENCY == 1) ? in_d : pd_q[PS-1];

    logic [RSP_W-1:0] fq [QDEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d, oc_q, oc_d;
    logic             pop;

    assign pop = bus.get_valid && (cnt_q != '0);

    always_comb begin
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop  ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q;
        oc_d  = oc_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        unique case ({in_v, pop})
            2'b10:   oc_d = oc_q + 1'b1;
            2'b01:   oc_d = oc_q - 1'b1;
            default: oc_d = oc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            oc_q  <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            oc_q  <= oc_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            fq[wp_q] <= push_d;
    end

    assign bus.put_ready    = RST_N && (oc_q < QFULL);
    assign bus.get_ready    = (cnt_q != '0);
    assign bus.get_response = fq[rp_q];

    logic [FA-1:0]         full_addr;
    logic [31:0]           addr32;
    logic                  is_exit;
    logic                  fin_q, fin_d;
    logic [DATA_WIDTH-1:0] code_q, code_d;

    assign full_addr = FA'({req_tag, req_idx}) << BS;
    assign addr32    = 32'(full_addr);
    assign is_exit   = acc && (addr32 == EXIT_ADDR0 || addr32 == EXIT_ADDR1);

    always_comb begin
        fin_d  = fin_q;
        code_d = code_q;
        if (is_exit && !fin_q) begin
            fin_d  = 1'b1;
            code_d = req_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fin_q  <= 1'b0;
            code_q <= '0;
        end else begin
            fin_q  <= fin_d;
            code_q <= code_d;
        end
    end

    assign finish    = fin_q;
    assign exit_code = code_q;
endmodule
